// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder for 1-bit RGB: two-stage pipeline, per-channel running disparity.
// Optional sticky disparity monitor (disp_err_o) enabled by defining TMDS_DISP_MON_EN.
module dvi_tmds_encoder #(
    parameter bit         SYNC_ACTIVE_LOW = 1'b1,
    parameter logic [7:0] COLOR_ON        = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       red_i,
    input  logic       green_i,
    input  logic       blue_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       de_i,
    output logic [9:0] tmds_red_o,
    output logic [9:0] tmds_green_o,
    output logic [9:0] tmds_blue_o
`ifdef TMDS_DISP_MON_EN
    ,
    output logic       disp_err_o
`endif
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    // Transition-minimising stage: q_m[8] = 1 marks the XOR chain.
    function automatic logic [8:0] encode_qm(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = 4'($countones(d));
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Channel index: 0 = blue, 1 = green, 2 = red.
    logic [2:0] color;
    logic [8:0] qm_c  [3];
    logic [3:0] n1_c  [3];
    logic       hs_act, vs_act;

    always_comb begin
        color  = {red_i, green_i, blue_i};
        hs_act = SYNC_ACTIVE_LOW ? ~hsync_i : hsync_i;
        vs_act = SYNC_ACTIVE_LOW ? ~vsync_i : vsync_i;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            qm_c[ch] = encode_qm(color[ch] ? COLOR_ON : '0);
            n1_c[ch] = 4'($countones(qm_c[ch][7:0]));
        end
    end

    logic [8:0] qm_s1 [3];
    logic [3:0] n1_s1 [3];
    logic [3:0] n0_s1 [3];
    logic       de_s1, c0_s1, c1_s1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                qm_s1[ch] <= '0;
                n1_s1[ch] <= '0;
                n0_s1[ch] <= '0;
            end
            de_s1 <= 1'b0;
            c0_s1 <= 1'b0;
            c1_s1 <= 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                qm_s1[ch] <= qm_c[ch];
                n1_s1[ch] <= n1_c[ch];
                n0_s1[ch] <= 4'd8 - n1_c[ch];
            end
            de_s1 <= de_i;
            c0_s1 <= hs_act;
            c1_s1 <= vs_act;
        end
    end

    logic signed [4:0] cnt_q  [3];
    logic        [9:0] tmds_q [3];
    logic        [9:0] q_c    [3];
    // One extra bit so an out-of-range update is observable before truncation.
    logic signed [5:0] nxt_c  [3];
    logic signed [5:0] n1s, n0s, diff, cur;
    logic        [9:0] tok;
    logic              qm8;

    always_comb begin
        n1s  = '0;
        n0s  = '0;
        diff = '0;
        cur  = '0;
        tok  = TOK_00;
        qm8  = 1'b0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            qm8  = qm_s1[ch][8];
            n1s  = signed'({2'b00, n1_s1[ch]});
            n0s  = signed'({2'b00, n0_s1[ch]});
            diff = n1s - n0s;
            cur  = signed'({cnt_q[ch][4], cnt_q[ch]});
            tok  = TOK_00;
            if (ch == 0) begin
                case ({c1_s1, c0_s1})
                    2'b00:   tok = TOK_00;
                    2'b01:   tok = TOK_01;
                    2'b10:   tok = TOK_10;
                    default: tok = TOK_11;
                endcase
            end
            if (!de_s1) begin
                q_c[ch]   = tok;
                nxt_c[ch] = '0;
            end else if ((cnt_q[ch] == 5'sd0) || (n1_s1[ch] == n0_s1[ch])) begin
                q_c[ch]   = {~qm8, qm8, qm8 ? qm_s1[ch][7:0] : ~qm_s1[ch][7:0]};
                nxt_c[ch] = cur + (qm8 ? diff : -diff);
            end else if (((cnt_q[ch] > 5'sd0) && (n1_s1[ch] > n0_s1[ch])) ||
                         ((cnt_q[ch] < 5'sd0) && (n0_s1[ch] > n1_s1[ch]))) begin
                q_c[ch]   = {1'b1, qm8, ~qm_s1[ch][7:0]};
                nxt_c[ch] = cur + (qm8 ? 6'sd2 : 6'sd0) - diff;
            end else begin
                q_c[ch]   = {1'b0, qm8, qm_s1[ch][7:0]};
                nxt_c[ch] = cur - (qm8 ? 6'sd0 : 6'sd2) + diff;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                tmds_q[ch] <= TOK_00;
                cnt_q[ch]  <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                tmds_q[ch] <= q_c[ch];
                cnt_q[ch]  <= nxt_c[ch][4:0];
            end
        end
    end

    assign tmds_blue_o  = tmds_q[0];
    assign tmds_green_o = tmds_q[1];
    assign tmds_red_o   = tmds_q[2];

`ifdef TMDS_DISP_MON_EN
    logic err_c;
    logic disp_err_q;

    always_comb begin
        err_c = 1'b0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            if (de_s1 && ((nxt_c[ch] > 6'sd10) || (nxt_c[ch] < -6'sd10) || nxt_c[ch][0])) begin
                err_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_err_q <= 1'b0;
        end else if (err_c) begin
            disp_err_q <= 1'b1;
        end
    end

    assign disp_err_o = disp_err_q;
`else
    logic unused_cnt_msb;
    assign unused_cnt_msb = ^{nxt_c[0][5], nxt_c[1][5], nxt_c[2][5]};
`endif

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed bench for dvi_tmds_encoder: constant-vector checks plus a behavioural
// reference encoder for mixed and pseudo-random pixel streams (default build).
module tb_dvi_tmds_encoder;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       red_i = 1'b0, green_i = 1'b0, blue_i = 1'b0;
    logic       hsync_i = 1'b1, vsync_i = 1'b1, de_i = 1'b0;
    logic [9:0] tmds_red_o, tmds_green_o, tmds_blue_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } exp_t;

    exp_t expq[$];
    int   cnt_r = 0, cnt_g = 0, cnt_b = 0;

    dvi_tmds_encoder #(
        .SYNC_ACTIVE_LOW (1'b1),
        .COLOR_ON        (8'hFF)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .red_i        (red_i),
        .green_i      (green_i),
        .blue_i       (blue_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .de_i         (de_i),
        .tmds_red_o   (tmds_red_o),
        .tmds_green_o (tmds_green_o),
        .tmds_blue_o  (tmds_blue_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [9:0] r, input logic [9:0] g,
                        input logic [9:0] b);
        chk({tag, "_red"},   tmds_red_o,   r);
        chk({tag, "_green"}, tmds_green_o, g);
        chk({tag, "_blue"},  tmds_blue_o,  b);
    endtask

    // Reference encoder written from the DVI algorithm using plain integers.
    task automatic ref_enc(input logic [7:0] d, input bit de, input bit [1:0] c,
                           input int ci, output int co, output logic [9:0] q);
        int       n1d, n1, n0;
        bit       x;
        bit [8:0] qm;
        n1d = $countones(d);
        x   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm  = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~x;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (!de) begin
            co = 0;
            case (c)
                2'b00:   q = TOK_00;
                2'b01:   q = TOK_01;
                2'b10:   q = TOK_10;
                default: q = TOK_11;
            endcase
        end else if (ci == 0 || n1 == n0) begin
            q  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            co = ci + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((ci > 0 && n1 > n0) || (ci < 0 && n0 > n1)) begin
            q  = {1'b1, qm[8], ~qm[7:0]};
            co = ci + 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            q  = {1'b0, qm[8], qm[7:0]};
            co = ci - 2 * int'(!qm[8]) + (n1 - n0);
        end
    endtask

    // Drive one pixel, record its expected symbol, advance one clock.
    task automatic px(input bit r, input bit g, input bit b, input bit hs, input bit vs,
                      input bit de);
        exp_t e;
        int   co;
        red_i = r; green_i = g; blue_i = b; hsync_i = hs; vsync_i = vs; de_i = de;
        ref_enc(r ? 8'hFF : 8'h00, de, 2'b00, cnt_r, co, e.r); cnt_r = co;
        ref_enc(g ? 8'hFF : 8'h00, de, 2'b00, cnt_g, co, e.g); cnt_g = co;
        ref_enc(b ? 8'hFF : 8'h00, de, {~vs, ~hs}, cnt_b, co, e.b); cnt_b = co;
        expq.push_back(e);
        if (expq.size() > 2) expq.delete(0);
        @(posedge clk);
        #1;
    endtask

    task automatic px_model(input bit r, input bit g, input bit b, input bit hs,
                            input bit vs, input bit de);
        px(r, g, b, hs, vs, de);
        if (expq.size() == 2) chk3("model", expq[0].r, expq[0].g, expq[0].b);
    endtask

    task automatic model_reset();
        expq.delete();
        cnt_r = 0; cnt_g = 0; cnt_b = 0;
    endtask

    initial begin
        // Reset with syncs deasserted (high = inactive).
        repeat (3) begin
            @(posedge clk);
            #1;
            chk3("reset", TOK_00, TOK_00, TOK_00);
        end
        rst_i = 1'b0;
        model_reset();
        px(0, 0, 0, 1, 1, 0);
        chk3("post_reset1", TOK_00, TOK_00, TOK_00);
        px(0, 0, 0, 1, 1, 0);
        chk3("post_reset2", TOK_00, TOK_00, TOK_00);

        // Control tokens on blue only.
        px(0, 0, 0, 0, 1, 0);
        px(0, 0, 0, 0, 1, 0);
        chk3("ctl_hs", TOK_00, TOK_00, TOK_01);
        px(0, 0, 0, 1, 0, 0);
        px(0, 0, 0, 1, 0, 0);
        chk3("ctl_vs", TOK_00, TOK_00, TOK_10);
        px(0, 0, 0, 0, 0, 0);
        px(0, 0, 0, 0, 0, 0);
        chk3("ctl_both", TOK_00, TOK_00, TOK_11);

        // All-zero pixels after blanking: 0x100, 0x3FF, 0x100.
        px(0, 0, 0, 1, 1, 0);
        px(0, 0, 0, 1, 1, 1);
        px(0, 0, 0, 1, 1, 1);
        chk3("zero_p0", 10'h100, 10'h100, 10'h100);
        px(0, 0, 0, 1, 1, 1);
        chk3("zero_p1", 10'h3FF, 10'h3FF, 10'h3FF);
        px(0, 0, 0, 1, 1, 0);
        chk3("zero_p2", 10'h100, 10'h100, 10'h100);

        // All-ones pixels: cnt -8, -2, +4, -4.
        px(1, 1, 1, 1, 1, 1);
        chk3("ones_blank", TOK_00, TOK_00, TOK_00);
        px(1, 1, 1, 1, 1, 1);
        chk3("ones_p0", 10'h200, 10'h200, 10'h200);
        px(1, 1, 1, 1, 1, 1);
        chk3("ones_p1", 10'h0FF, 10'h0FF, 10'h0FF);
        px(1, 1, 1, 1, 1, 1);
        chk3("ones_p2", 10'h0FF, 10'h0FF, 10'h0FF);
        px(0, 0, 0, 1, 1, 0);
        chk3("ones_p3", 10'h200, 10'h200, 10'h200);
        px(0, 0, 0, 0, 1, 0);
        chk3("ones_end", TOK_00, TOK_00, TOK_00);

        // Alternating pixels, one-cycle blank, then resume from cnt=0.
        for (int i = 0; i < 8; i++) px_model(i[0], ~i[0], i[1], 1, 1, 1);
        px_model(1, 0, 1, 0, 1, 0);
        px_model(1, 0, 1, 1, 1, 1);
        chk3("blank_token", TOK_00, TOK_00, TOK_01);
        px_model(0, 1, 0, 1, 1, 1);
        chk3("resume_fresh", 10'h200, 10'h100, 10'h200);
        for (int i = 0; i < 6; i++) px_model(i[0], i[1], ~i[0], 1, 1, 1);

        // Pseudo-random stream, mostly active video.
        for (int i = 0; i < 400; i++) begin
            logic [5:0] v;
            v = 6'($urandom);
            px_model(v[0], v[1], v[2], v[3], v[4], ($urandom_range(0, 7) != 0));
        end

        // Mid-line reset with active video on the inputs.
        px_model(1, 0, 1, 1, 1, 1);
        px_model(0, 1, 1, 1, 1, 1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk3("midline_rst", TOK_00, TOK_00, TOK_00);
        rst_i = 1'b0;
        model_reset();
        px(0, 0, 0, 1, 1, 1);
        chk3("rst_no_stale", TOK_00, TOK_00, TOK_00);
        px_model(0, 0, 0, 1, 1, 1);
        chk3("rst_first_px", 10'h100, 10'h100, 10'h100);
        for (int i = 0; i < 20; i++) px_model(i[1], i[0], i[2], 1, 1, (i != 9));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
